core_link_fifo: RTL and testbench

Byte FIFO that links one output port of a producer `jimmy` core to one input port of a consumer core in the multicore build. Pushes on the producer's active-low `out_strobe` bit and pops on the consumer's active-low `in_strobe` bit. Exposes the FIFO head on a data byte and occupancy/error flags on a status byte; the consumer reads each byte through its own `in_port`.

---
 rtl/core_link_pkg.sv | 16 +
 rtl/strobe_fall_detect.sv | 19 +
 rtl/core_link_fifo.sv | 81 ++++++++
 tb/tb_core_link_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/core_link_pkg.sv
// Shared constants for the core-to-core byte link: status byte layout,
// default depth and the value presented on the data port when the FIFO is empty.
package core_link_pkg;

    localparam int ST_EMPTY     = 7;
    localparam int ST_FULL      = 6;
    localparam int ST_OVF       = 5;
    localparam int ST_UNF       = 4;
    localparam int ST_CNT_MSB   = 3;
    localparam int ST_CNT_LSB   = 0;

    localparam int DEPTH_DEFAULT = 8;

    localparam logic [7:0] EMPTY_DATA = 8'h00;

endpackage

// File: rtl/strobe_fall_detect.sv
// Turns an active-low core strobe into a single-cycle event; a strobe held
// low for several cycles still yields exactly one event.
module strobe_fall_detect (
    input  logic clk,
    input  logic reset,
    input  logic strobe_n,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= 1'b1;
        else       prev <= strobe_n;
    end

    assign fall = prev & ~strobe_n;

endmodule

// File: rtl/core_link_fifo.sv
// Byte FIFO linking a producer core's output port to a consumer core's input
// ports; the head byte and a status byte are both readable by the consumer.
module core_link_fifo
    import core_link_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_strobe_n,
    input  logic       rd_strobe_n,
    input  logic       stat_strobe_n,
    output logic [7:0] rd_data,
    output logic [7:0] status
);

    localparam int         PW        = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

    // Strobe protocol: each active-low strobe is a request; its falling edge
    // (low now, high last cycle) is the single event acted on, with no ready.
    logic wr_ev, rd_ev, stat_ev;

    strobe_fall_detect u_wr_det   (.clk(clk), .reset(reset), .strobe_n(wr_strobe_n),   .fall(wr_ev));
    strobe_fall_detect u_rd_det   (.clk(clk), .reset(reset), .strobe_n(rd_strobe_n),   .fall(rd_ev));
    strobe_fall_detect u_stat_det (.clk(clk), .reset(reset), .strobe_n(stat_strobe_n), .fall(stat_ev));

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    count;
    logic          overflow, underflow;

    logic is_empty, is_full;
    logic do_push, do_pop, ovf_set, unf_set;

    assign is_empty = (count == 4'd0);
    assign is_full  = (count == DEPTH_CNT);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = wr_ev & (~is_full | rd_ev);
    assign do_pop  = rd_ev & ~is_empty;
    assign ovf_set = wr_ev & is_full & ~rd_ev;
    assign unf_set = rd_ev & is_empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 4'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            // Set wins over a read-to-clear in the same cycle.
            overflow  <= ovf_set | (overflow  & ~stat_ev);
            underflow <= unf_set | (underflow & ~stat_ev);
        end
    end

    always_comb begin
        rd_data = is_empty ? EMPTY_DATA : mem[rd_ptr];
        status  = 8'h00;
        status[ST_EMPTY] = is_empty;
        status[ST_FULL]  = is_full;
        status[ST_OVF]   = overflow;
        status[ST_UNF]   = underflow;
        status[ST_CNT_MSB:ST_CNT_LSB] = count;
    end

endmodule

// File: tb/tb_core_link_fifo.sv
// Bench for core_link_fifo: table of strobe vectors, hand-written corner
// sequences, and random traffic against a queue-based reference model.
module tb_core_link_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_strobe_n, rd_strobe_n, stat_strobe_n;
    logic [7:0] rd_data;
    logic [7:0] status;

    int total = 0;
    int bad   = 0;

    core_link_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data),
        .wr_strobe_n(wr_strobe_n), .rd_strobe_n(rd_strobe_n), .stat_strobe_n(stat_strobe_n),
        .rd_data(rd_data), .status(status)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue plus sticky flags and last-seen strobe levels.
    logic [7:0] m_q[$];
    logic       m_ovf, m_unf;
    logic       m_pw, m_pr, m_ps;

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
        m_pw = 1'b1; m_pr = 1'b1; m_ps = 1'b1;
    endtask

    task automatic model_edge(input logic w, input logic r, input logic s, input logic [7:0] d);
        logic we, re, se, full, empty, oset, uset;
        we = !w && m_pw; re = !r && m_pr; se = !s && m_ps;
        m_pw = w; m_pr = r; m_ps = s;
        full = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        oset = 1'b0; uset = 1'b0;
        if (re) begin
            if (empty) uset = 1'b1;
            else void'(m_q.pop_front());
        end
        if (we) begin
            if (!full || re) m_q.push_back(d);
            else oset = 1'b1;
        end
        m_ovf = oset || (m_ovf && !se);
        m_unf = uset || (m_unf && !se);
    endtask

    function automatic logic [7:0] exp_rd();
        return (m_q.size() == 0) ? 8'h00 : m_q[0];
    endfunction

    function automatic logic [7:0] exp_status();
        logic [7:0] st;
        st = {m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_unf, 4'(m_q.size())};
        return st;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rd_data"}, rd_data, exp_rd());
        check({tag, ".status"},  status,  exp_status());
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, compare at the next negedge.
    task automatic step(input logic w, input logic r, input logic s, input logic [7:0] d);
        wr_strobe_n = w; rd_strobe_n = r; stat_strobe_n = s; wr_data = d;
        model_edge(w, r, s, d);
        @(posedge clk);
        @(negedge clk);
        check_model("model");
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b0, 1'b1, 1'b1, d);
        idle();
    endtask

    task automatic pop();
        step(1'b1, 1'b0, 1'b1, 8'h00);
        idle();
    endtask

    task automatic async_reset();
        wr_strobe_n = 1'b1; rd_strobe_n = 1'b1; stat_strobe_n = 1'b1;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("reset.rd_data", rd_data, 8'h00);
        check("reset.status",  status,  8'h80);
        @(negedge clk);
        reset = 1'b0;
        check("reset_rel.status", status, 8'h80);
    endtask

    typedef struct {
        logic       w, r, s;
        logic [7:0] d;
        logic [7:0] exp_rd;
        logic [7:0] exp_st;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset = 1'b1;
        wr_data = 8'h00;
        wr_strobe_n = 1'b1; rd_strobe_n = 1'b1; stat_strobe_n = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("init.rd_data", rd_data, 8'h00);
        check("init.status",  status,  8'h80);

        // Each row is one strobe cycle followed by one idle cycle.
        vecs = '{
            '{1'b0, 1'b1, 1'b1, 8'h11, 8'h11, 8'h01},
            '{1'b0, 1'b1, 1'b1, 8'h22, 8'h11, 8'h02},
            '{1'b0, 1'b1, 1'b1, 8'h33, 8'h11, 8'h03},
            '{1'b1, 1'b0, 1'b1, 8'h00, 8'h22, 8'h02},
            '{1'b1, 1'b0, 1'b1, 8'h00, 8'h33, 8'h01},
            '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h80},
            '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h90},
            '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h80},
            '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h90},
            '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h80},
            '{1'b0, 1'b0, 1'b1, 8'h5A, 8'h5A, 8'h11},
            '{1'b1, 1'b1, 1'b0, 8'h00, 8'h5A, 8'h01},
            '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h80}
        };
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].w, vecs[i].r, vecs[i].s, vecs[i].d);
            check($sformatf("vec%0d.rd_data", i), rd_data, vecs[i].exp_rd);
            check($sformatf("vec%0d.status", i),  status,  vecs[i].exp_st);
            idle();
            check($sformatf("vec%0d_idle.status", i), status, vecs[i].exp_st);
        end

        // Reset mid-stream with three entries held.
        push(8'hA1); push(8'hA2); push(8'hA3);
        check("pre_reset.status", status, 8'h03);
        async_reset();

        // Overflow: nine pushes into eight slots, then drain.
        for (int i = 1; i <= 9; i++) push(8'(i));
        check("ovf.status", status, 8'h68);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain%0d.rd_data", i), rd_data, 8'(i));
            pop();
        end
        check("drained.status", status, 8'hA0);
        step(1'b1, 1'b1, 1'b0, 8'h00); idle();
        check("ovf_clr.status", status, 8'h80);

        // Push and pop together while full.
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        step(1'b0, 1'b0, 1'b1, 8'hEE); idle();
        check("full_both.status",  status,  8'h48);
        check("full_both.rd_data", rd_data, 8'h41);
        for (int i = 0; i < 8; i++) pop();
        check("full_both_tail.status", status, 8'h80);

        // A strobe held low for four cycles pushes once.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'hC0 + 8'(i));
        idle();
        check("held.status",  status,  8'h01);
        check("held.rd_data", rd_data, 8'hC0);
        pop();

        // Random traffic, including back-to-back strobes and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
            end else begin
                step(($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1,
                     ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1,
                     ($urandom_range(0, 9) < 1) ? 1'b0 : 1'b1,
                     8'($urandom_range(0, 255)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete within time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
